cache_control_fsm: RTL
======================

# cache_control_fsm

Control state machine for the 2-way set-associative write-back cache. It sequences CPU requests through tag check, dirty-victim writeback and line fill. It drives the set/clear dirty strobes consumed by the dirty-bit load logic, the LRU update, the line-fill load and the physical-memory handshake. It sits between the CPU-side request interface and the cache datapath/physical memory.

## Interface
- CNT_WIDTH, 32, width of the performance counters

- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  reset, asynchronous, active-low; one clock, no other reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- hit  in  1  tag match on a valid line in either way (datapath, combinational)
- cmp_rst  in  1  way that hit (0/1); valid only when hit=1
- lru  in  1  LRU way of the addressed set; this is the victim way
- dirty_0, dirty_1  in  1 each  dirty bits of way 0/1 in the addressed set
- pmem_resp  in  1  physical-memory completion, one-cycle pulse
- mem_resp  out  1  CPU completion pulse
- set_dirty  out  1  mark the hit way dirty (write hit)
- clr_dirty  out  1  clear the victim way's dirty bit
- lru_load  out  1  write lru_data into the set's LRU bit
- lru_data  out  1  new LRU value
- fill_load  out  1  load data/tag/valid of the victim way from pmem
- pmem_read  out  1  physical-memory line read
- pmem_write  out  1  physical-memory line write
- pmem_addr_sel  out  1  1 = victim tag address (writeback), 0 = CPU address
- hit_count, miss_count, wb_count  out  CNT_WIDTH each  performance counters

## Operation
- States: IDLE, TAG_CHECK, WRITEBACK, FILL. Reset state is IDLE.
- IDLE: no outputs asserted. Moves to TAG_CHECK when mem_read|mem_write.
- TAG_CHECK, request present and hit=1:
  - mem_resp=1, lru_load=1, lru_data=~cmp_rst.
  - If mem_write, also set_dirty=1.
  - Next state IDLE.
- TAG_CHECK, request present and hit=0:
  - Victim dirty = (lru ? dirty_1 : dirty_0).
  - Dirty victim: next state WRITEBACK. Clean victim: next state FILL. No outputs asserted.
- TAG_CHECK with both requests deasserted (protocol violation): next state IDLE, no outputs.
- mem_read and mem_write both set: treated as a write.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, held until pmem_resp.
  - In the pmem_resp cycle, clr_dirty=1, then next state FILL.
- FILL:
  - pmem_read=1, pmem_addr_sel=0, held until pmem_resp.
  - In the pmem_resp cycle, fill_load=1, then next state TAG_CHECK. The retry then hits.
- pmem_resp in IDLE or TAG_CHECK is ignored.
- set_dirty and clr_dirty are never asserted in the same cycle.

## Timing
- pmem_read, pmem_write and pmem_addr_sel are Moore outputs decoded from the state register.
- mem_resp, set_dirty, lru_load, lru_data, clr_dirty and fill_load are Mealy outputs, valid in the same cycle as their qualifying inputs.
- Hit latency: request seen in IDLE at edge n; mem_resp high during cycle n+1.
- Clean miss: TAG_CHECK, FILL for k cycles until pmem_resp, TAG_CHECK, then mem_resp. mem_resp comes 2+k cycles after entering TAG_CHECK.
- Dirty miss: adds the WRITEBACK wait plus one cycle.
- Reset asserted at any point, including mid-WRITEBACK or mid-FILL:
  - State goes to IDLE immediately, without waiting for a clock edge.
  - All outputs go to 0, counters go to 0.
  - An in-flight pmem transaction is abandoned.

## Configuration
- Macro: CACHE_CTRL_PERF_CNT_EN.
- Defined:
  - hit_count increments on a TAG_CHECK hit that is not a post-fill retry. An internal retry flag is set on leaving FILL and cleared on mem_resp.
  - miss_count increments on each TAG_CHECK miss.
  - wb_count increments on WRITEBACK completion.
  - All three counters saturate at all-ones and do not wrap.
- Undefined: the counter ports still exist and are tied to 0. No counter or retry-flag logic is synthesized.

## Test plan
- Read hit: hit=1, cmp_rst=1, mem_read → 1 cycle after request, mem_resp=1, lru_load=1, lru_data=0, set_dirty=0; hit_count=1.
- Write hit: hit=1, cmp_rst=0, mem_write → mem_resp=1, set_dirty=1, lru_data=1 in the same cycle.
- Clean miss: hit=0, lru=0, dirty_0=0, pmem_resp after 5 cycles → pmem_read high for 5 cycles, then fill_load=1. Retry with hit=1 gives mem_resp; miss_count=1, hit_count=0.
- Dirty miss: lru=1, dirty_1=1 → pmem_write with pmem_addr_sel=1 until pmem_resp, then clr_dirty=1, then FILL, then mem_resp. wb_count=1.
- Reset mid-FILL: drop reset_n during FILL → pmem_read=0 with no clock edge. After release, the FSM is in IDLE with all counters 0.
- Saturation: CNT_WIDTH=2, five read hits → hit_count=3.

Source files
------------

// File: rtl/cache_control_fsm.sv
// Control FSM for the 2-way write-back cache: tag check, dirty-victim writeback, line fill, pmem handshake.
// Optional performance counters are enabled with the CACHE_CTRL_PERF_CNT_EN macro (otherwise tied to 0).
module cache_control_fsm #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 hit,
    input  logic                 cmp_rst,
    input  logic                 lru,
    input  logic                 dirty_0,
    input  logic                 dirty_1,
    input  logic                 pmem_resp,
    output logic                 mem_resp,
    output logic                 set_dirty,
    output logic                 clr_dirty,
    output logic                 lru_load,
    output logic                 lru_data,
    output logic                 fill_load,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 pmem_addr_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TAG_CHECK = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   req;
    logic   victim_dirty;

    assign req          = mem_read | mem_write;
    assign victim_dirty = lru ? dirty_1 : dirty_0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Moore pmem outputs decode the state register; the rest are Mealy on the current inputs.
    always_comb begin
        next_state    = state;
        mem_resp      = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        lru_load      = 1'b0;
        lru_data      = 1'b0;
        fill_load     = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = TAG_CHECK;
                end
            end
            TAG_CHECK: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (hit) begin
                    mem_resp   = 1'b1;
                    lru_load   = 1'b1;
                    lru_data   = ~cmp_rst;
                    set_dirty  = mem_write;
                    next_state = IDLE;
                end else if (victim_dirty) begin
                    next_state = WRITEBACK;
                end else begin
                    next_state = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    clr_dirty  = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_load  = 1'b1;
                    next_state = TAG_CHECK;
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef CACHE_CTRL_PERF_CNT_EN
    // retry marks the tag check that follows a fill so it is not counted as a hit.
    logic retry;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry      <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == FILL && pmem_resp) begin
                retry <= 1'b1;
            end else if (mem_resp) begin
                retry <= 1'b0;
            end
            if (state == TAG_CHECK && req) begin
                if (hit) begin
                    if (!retry && hit_count != '1) begin
                        hit_count <= hit_count + CNT_WIDTH'(1);
                    end
                end else if (miss_count != '1) begin
                    miss_count <= miss_count + CNT_WIDTH'(1);
                end
            end
            if (state == WRITEBACK && pmem_resp && wb_count != '1) begin
                wb_count <= wb_count + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule
